search_controller: RTL and testbench
====================================

Name: search_controller

Overview:
- Sequences one search pass per UCI "go" between uci_handler and move_generator.
- Latches the board and launches move_generator with a valid/ready handshake.
- Collects the scored move stream and keeps the highest-scoring move.
- Reports the best move to uci_handler on generator completion, stop, or timeout.

Parameters:
- SCORE_W, 16, width of the signed move score.
- CNT_W, 8, width of the move counter (saturating).
- TIMEOUT_CYCLES, 1000000, cycles allowed in COLLECT before forced report; 0 disables timeout.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- board_in  input  board_t  position from uci_handler
- board_valid_in  input  1  board_in valid; sampled only in IDLE
- go_in  input  1  start search pulse
- stop_in  input  1  terminate search and report best so far
- mg_board_out  output  board_t  latched board to move_generator
- mg_valid_out  output  1  launch request to move_generator
- mg_ready_in  input  1  move_generator accepts launch
- mg_move_in  input  move_t  generated move
- mg_score_in  input  SCORE_W  signed score of mg_move_in
- mg_move_valid_in  input  1  mg_move_in/mg_score_in valid
- mg_last_in  input  1  qualifies final move of stream (with mg_move_valid_in), or empty stream (alone)
- mg_abort_out  output  1  one-cycle flush pulse to move_generator
- best_move_out  output  move_t  best move found
- best_move_valid_out  output  1  one-cycle report pulse
- no_move_out  output  1  qualifies best_move_valid_out: zero moves seen
- move_count_out  output  CNT_W  moves seen in current/last search
- busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; board register cleared; board_loaded flag cleared.
- States: IDLE, LAUNCH, COLLECT, REPORT.
- IDLE:
  - board_valid_in latches board_in into the board register and sets board_loaded; board_valid_in is ignored in other states.
  - go_in with board_loaded set -> LAUNCH. go_in without board_loaded is ignored.
  - On the LAUNCH transition: clear move_count, best score = most negative SCORE_W value, best_move = 0, timer = 0.
  - If board_valid_in and go_in are high in the same cycle, the new board is latched and used for the launch.
- LAUNCH:
  - mg_valid_out held high and mg_board_out stable until mg_ready_in.
  - Handshake cycle -> COLLECT.
  - stop_in -> REPORT with no_move_out=1; mg_valid_out drops and no abort is sent.
- COLLECT, on mg_move_valid_in:
  - move_count increments, saturating at 2^CNT_W-1.
  - If signed mg_score_in > best score, best_move/best score update. Ties keep the earlier move. The first move always replaces the initial best.
- COLLECT exits:
  - mg_last_in with mg_move_valid_in: that move is evaluated, then -> REPORT.
  - mg_last_in without mg_move_valid_in (empty stream): -> REPORT.
  - stop_in, or timer reaching TIMEOUT_CYCLES-1 when TIMEOUT_CYCLES != 0: mg_abort_out pulses 1 cycle, then -> REPORT. A move arriving in that same cycle is still evaluated.
  - Priority when events coincide: last > stop > timeout, with at most one abort pulse.
- REPORT:
  - best_move_valid_out=1 for exactly one cycle; no_move_out = (move_count==0) on that cycle.
  - best_move_out holds the value until the next launch. Next state IDLE.
- Latency: go_in to mg_valid_out is 1 cycle. mg_last_in to best_move_valid_out is 1 cycle.
- mg_move_valid_in outside COLLECT is ignored. go_in outside IDLE is ignored. board_loaded persists across searches.
- busy_out is registered from the state.

Optional Feature:
- SEARCH_STATS_EN defined: adds output search_cycles_out (32 bits).
  - Counts cycles from entering LAUNCH to REPORT, saturating at all-ones.
  - Valid when best_move_valid_out is high; holds until the next launch; reset 0.
- SEARCH_STATS_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Load board, go, ready after 3 cycles; moves with scores 5, -2, 9, 9(last) -> best_move_valid_out pulses once, best = 3rd move, move_count_out=4, no_move_out=0, no mg_abort_out.
- Go with no board_valid_in since reset -> stays IDLE, mg_valid_out stays 0, busy_out=0.
- Empty stream: mg_last_in alone in COLLECT -> report with no_move_out=1, best_move_out=0, move_count_out=0.
- TIMEOUT_CYCLES=20, generator sends 2 moves then stalls -> mg_abort_out single pulse at cycle 20 of COLLECT; report carries best of the 2 moves.
- stop_in in the same cycle as a move with score 100 (best so far 10) -> that move becomes best, one abort pulse, report on the next cycle. Separately, stop_in during LAUNCH -> no abort pulse, no_move_out=1.
- rst_in low mid-COLLECT -> all outputs 0 immediately (async); after release, go_in is ignored until a new board_valid_in.

Source files
------------

// File: rtl/search_controller.sv
// Runs one search pass per "go": latches the board, launches move_generator, and keeps the best-scoring move.
// Optional SEARCH_STATS_EN adds search_cycles_out, a 32-bit saturating count of cycles from LAUNCH to REPORT.
package search_pkg;
    typedef struct packed {
        logic [63:0][3:0] sq;
    } board_t;

    typedef struct packed {
        logic [5:0] from_sq;
        logic [5:0] to_sq;
        logic [3:0] promo;
    } move_t;
endpackage

module search_controller
    import search_pkg::*;
#(
    parameter int          SCORE_W        = 16,
    parameter int          CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  board_t                    board_in,
    input  logic                      board_valid_in,
    input  logic                      go_in,
    input  logic                      stop_in,
    output board_t                    mg_board_out,
    output logic                      mg_valid_out,
    input  logic                      mg_ready_in,
    input  move_t                     mg_move_in,
    input  logic signed [SCORE_W-1:0] mg_score_in,
    input  logic                      mg_move_valid_in,
    input  logic                      mg_last_in,
    output logic                      mg_abort_out,
    output move_t                     best_move_out,
    output logic                      best_move_valid_out,
    output logic                      no_move_out,
    output logic [CNT_W-1:0]          move_count_out,
`ifdef SEARCH_STATS_EN
    output logic [31:0]               search_cycles_out,
`endif
    output logic                      busy_out
);

    typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, REPORT} state_t;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t                      state_q, state_d;
    board_t                      board_q, board_d;
    logic                        loaded_q, loaded_d;
    move_t                       best_move_q, best_move_d;
    logic signed [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [31:0]                 timer_q, timer_d;
    logic                        busy_q;

    logic start;
    logic timeout_hit;
    logic better;

    // A board arriving with go is latched and launched in the same cycle.
    assign start       = (state_q == IDLE) && go_in && (loaded_q || board_valid_in);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST);
    assign better      = (count_q == '0) || (mg_score_in > best_score_q);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            board_q      <= '0;
            loaded_q     <= 1'b0;
            best_move_q  <= '0;
            best_score_q <= SCORE_MIN;
            count_q      <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            loaded_q     <= loaded_d;
            best_move_q  <= best_move_d;
            best_score_q <= best_score_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LAUNCH;
            LAUNCH:  if (stop_in) state_d = REPORT;
                     else if (mg_ready_in) state_d = COLLECT;
            COLLECT: if (mg_last_in || stop_in || timeout_hit) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        board_d      = board_q;
        loaded_d     = loaded_q;
        best_move_d  = best_move_q;
        best_score_d = best_score_q;
        count_d      = count_q;
        timer_d      = timer_q;
        if (state_q == IDLE && board_valid_in) begin
            board_d  = board_in;
            loaded_d = 1'b1;
        end
        if (start) begin
            best_move_d  = '0;
            best_score_d = SCORE_MIN;
            count_d      = '0;
            timer_d      = '0;
        end
        if (state_q == COLLECT) begin
            timer_d = timer_q + 32'd1;
            if (mg_move_valid_in) begin
                if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
                // Strict compare keeps the earlier move on ties.
                if (better) begin
                    best_move_d  = mg_move_in;
                    best_score_d = mg_score_in;
                end
            end
        end
    end

    always_comb begin
        mg_valid_out        = (state_q == LAUNCH);
        mg_abort_out        = (state_q == COLLECT) && !mg_last_in && (stop_in || timeout_hit);
        best_move_valid_out = (state_q == REPORT);
        no_move_out         = (state_q == REPORT) && (count_q == '0);
        mg_board_out        = board_q;
        best_move_out       = best_move_q;
        move_count_out      = count_q;
        busy_out            = busy_q;
    end

`ifdef SEARCH_STATS_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycles_q <= '0;
        end else if (start) begin
            cycles_q <= '0;
        end else if ((state_q == LAUNCH || state_q == COLLECT) && cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign search_cycles_out = cycles_q;
`endif

endmodule

// File: tb/tb_search_controller.sv
// Directed bench for search_controller; expected reports queue into a scoreboard checked by a monitor.
module tb_search_controller;
    import search_pkg::*;

    localparam int SCORE_W = 16;
    localparam int CNT_W   = 8;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b0;
    board_t                    board_in = '0;
    logic                      board_valid_in = 1'b0;
    logic                      go_in = 1'b0;
    logic                      stop_in = 1'b0;
    board_t                    mg_board_out;
    logic                      mg_valid_out;
    logic                      mg_ready_in = 1'b0;
    move_t                     mg_move_in = '0;
    logic signed [SCORE_W-1:0] mg_score_in = '0;
    logic                      mg_move_valid_in = 1'b0;
    logic                      mg_last_in = 1'b0;
    logic                      mg_abort_out;
    move_t                     best_move_out;
    logic                      best_move_valid_out;
    logic                      no_move_out;
    logic [CNT_W-1:0]          move_count_out;
    logic                      busy_out;
`ifdef SEARCH_STATS_EN
    logic [31:0]               search_cycles_out;
`endif

    search_controller #(.SCORE_W(SCORE_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(20)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .board_in(board_in), .board_valid_in(board_valid_in),
        .go_in(go_in), .stop_in(stop_in),
        .mg_board_out(mg_board_out), .mg_valid_out(mg_valid_out), .mg_ready_in(mg_ready_in),
        .mg_move_in(mg_move_in), .mg_score_in(mg_score_in),
        .mg_move_valid_in(mg_move_valid_in), .mg_last_in(mg_last_in),
        .mg_abort_out(mg_abort_out),
        .best_move_out(best_move_out), .best_move_valid_out(best_move_valid_out),
        .no_move_out(no_move_out), .move_count_out(move_count_out),
`ifdef SEARCH_STATS_EN
        .search_cycles_out(search_cycles_out),
`endif
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        move_t            mv;
        logic             nm;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks  = 0;
    int     n_fail    = 0;
    int     abort_cnt = 0;
    move_t  mv[10];
    board_t b1, b2, b_junk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk_in) begin
        if (mg_abort_out === 1'b1) abort_cnt++;
        if (best_move_valid_out === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_report: got move %0h with none expected", best_move_out);
            end else begin
                e = exp_q.pop_front();
                check("report_move", best_move_out, e.mv);
                check("report_no_move", no_move_out, e.nm);
                check("report_count", move_count_out, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input move_t m, input logic nm, input int cnt);
        exp_t e;
        e.mv  = m;
        e.nm  = nm;
        e.cnt = CNT_W'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic do_go(input board_t b, input logic new_board);
        board_in       = b;
        board_valid_in = new_board;
        go_in          = 1'b1;
        tick();
        go_in          = 1'b0;
        board_valid_in = 1'b0;
    endtask

    task automatic handshake(input int wait_cyc);
        repeat (wait_cyc) tick();
        check("launch_hold", mg_valid_out, 1'b1);
        mg_ready_in = 1'b1;
        tick();
        mg_ready_in = 1'b0;
    endtask

    task automatic send(input move_t m, input int s, input logic last, input logic stop);
        mg_move_in       = m;
        mg_score_in      = SCORE_W'(s);
        mg_move_valid_in = 1'b1;
        mg_last_in       = last;
        stop_in          = stop;
        tick();
        mg_move_valid_in = 1'b0;
        mg_last_in       = 1'b0;
        stop_in          = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        check("report_arrived", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int abort_at;
        for (int i = 0; i < 10; i++) mv[i] = move_t'({6'(i), 6'(i + 20), 4'(i)});
        for (int i = 0; i < 64; i++) begin
            b1.sq[i]     = 4'(i);
            b2.sq[i]     = 4'(15 - (i % 16));
            b_junk.sq[i] = 4'h7;
        end

        // Reset state
        #12;
        check("rst_mg_valid", mg_valid_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_report", {best_move_valid_out, no_move_out, mg_abort_out}, 3'b000);
        check("rst_count", move_count_out, '0);
        check("rst_best", best_move_out, '0);
        check("rst_board", mg_board_out, '0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        tick();

        // Go without any board loaded is ignored
        do_go(b_junk, 1'b0);
        tick();
        check("noboard_busy", busy_out, 1'b0);
        check("noboard_mg_valid", mg_valid_out, 1'b0);

        // Main search: 5, -2, 9, 9(last); tie keeps the third move
        board_in = b1; board_valid_in = 1'b1;
        tick();
        board_valid_in = 1'b0;
        a0 = abort_cnt;
        push_exp(mv[3], 1'b0, 4);
        do_go(b_junk, 1'b0);
        check("launch_valid", mg_valid_out, 1'b1);
        check("launch_board", mg_board_out, b1);
        check("launch_busy", busy_out, 1'b1);
        handshake(3);
        check("collect_mg_valid", mg_valid_out, 1'b0);
        send(mv[1], 5, 1'b0, 1'b0);
        send(mv[2], -2, 1'b0, 1'b0);
        send(mv[3], 9, 1'b0, 1'b0);
        send(mv[4], 9, 1'b1, 1'b0);
        drain();
        check("main_no_abort", abort_cnt - a0, 0);
        check("main_idle_busy", busy_out, 1'b0);
        tick();
        check("main_best_hold", best_move_out, mv[3]);

        // Empty stream, board and go in the same cycle
        push_exp('0, 1'b1, 0);
        do_go(b2, 1'b1);
        check("same_cycle_board", mg_board_out, b2);
        handshake(0);
        mg_last_in = 1'b1;
        tick();
        mg_last_in = 1'b0;
        drain();
        tick();

        // Timeout after two moves
        a0 = abort_cnt;
        abort_at = -1;
        push_exp(mv[6], 1'b0, 2);
        do_go(b_junk, 1'b0);
        handshake(1);
        send(mv[5], 3, 1'b0, 1'b0);
        send(mv[6], 7, 1'b0, 1'b0);
        for (int k = 2; k < 30; k++) begin
            @(negedge clk_in);
            if (mg_abort_out === 1'b1 && abort_at < 0) abort_at = k;
            @(posedge clk_in);
            #1;
        end
        check("timeout_cycle", abort_at, 19);
        check("timeout_one_abort", abort_cnt - a0, 1);
        drain();

        // Stop coinciding with a better move
        a0 = abort_cnt;
        push_exp(mv[8], 1'b0, 2);
        do_go(b_junk, 1'b0);
        handshake(0);
        send(mv[7], 10, 1'b0, 1'b0);
        mg_move_in = mv[8]; mg_score_in = 16'sd100; mg_move_valid_in = 1'b1; stop_in = 1'b1;
        @(negedge clk_in);
        check("stop_abort_now", mg_abort_out, 1'b1);
        @(posedge clk_in);
        #1;
        mg_move_valid_in = 1'b0; stop_in = 1'b0;
        drain();
        check("stop_one_abort", abort_cnt - a0, 1);
        tick();

        // Stop during LAUNCH: no abort, no move
        a0 = abort_cnt;
        push_exp('0, 1'b1, 0);
        do_go(b_junk, 1'b0);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("launch_stop_mg_valid", mg_valid_out, 1'b0);
        drain();
        check("launch_stop_no_abort", abort_cnt - a0, 0);
        tick();

        // Last and stop together: last wins, negative first move still replaces
        a0 = abort_cnt;
        push_exp(mv[9], 1'b0, 1);
        do_go(b_junk, 1'b0);
        handshake(0);
        send(mv[9], -5, 1'b1, 1'b1);
        drain();
        check("last_over_stop_no_abort", abort_cnt - a0, 0);
        tick();

        // Asynchronous reset mid-COLLECT clears board_loaded
        do_go(b_junk, 1'b0);
        handshake(0);
        send(mv[1], 4, 1'b0, 1'b0);
        check("pre_rst_busy", busy_out, 1'b1);
        rst_in = 1'b0;
        #1;
        check("async_rst_busy", busy_out, 1'b0);
        check("async_rst_count", move_count_out, '0);
        check("async_rst_best", best_move_out, '0);
        check("async_rst_board", mg_board_out, '0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        do_go(b_junk, 1'b0);
        tick();
        check("post_rst_go_ignored", {busy_out, mg_valid_out}, 2'b00);
        board_in = b2; board_valid_in = 1'b1;
        tick();
        board_valid_in = 1'b0;
        push_exp('0, 1'b1, 0);
        do_go(b_junk, 1'b0);
        check("post_rst_launch_board", mg_board_out, b2);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        drain();

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
